dds_cmd_scheduler: RTL and testbench
====================================

Name: dds_cmd_scheduler

Overview:
Arbitrates and sequences 32-bit DDS register-write words from two requesters onto the DDS parallel-port transfer engine. Requester 0 is the VIO/manual path; requester 1 is the sweep/sequence path. Words are grouped into batches, and a batch is never interleaved with the other requester's words. The block issues one engine start per word, waits for completion, inserts an inter-word gap, and raises IO_update once after each batch's last word. An engine watchdog is included.

Parameters:
GAP_CYC, 4, idle cycles after each word (or after IO_update) before the next accept; legal range >= 1
IOUP_CYC, 2, io_update pulse width in clk cycles; legal range >= 1
TIMEOUT, 255, max cycles in WAIT without x_done before abort; legal range 2..255

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
s0_valid  in  1  requester 0 word valid
s0_data  in  32  requester 0 word ({addr/data bytes}, MSB byte first on bus)
s0_last  in  1  word is the last of its batch
s0_ready  out  1  requester 0 word accepted this cycle when valid
s1_valid  in  1  requester 1 word valid
s1_data  in  32  requester 1 word
s1_last  in  1  requester 1 last-of-batch
s1_ready  out  1  requester 1 accept
x_start  out  1  one-cycle start pulse to transfer engine
x_data  out  32  word for engine; stable from x_start until x_done
x_done  in  1  one-cycle completion pulse from engine
io_update  out  1  DDS IO_update strobe
grant  out  2  one-hot current batch owner; 00 when no batch is open
busy  out  1  high in any state other than IDLE
err_timeout  out  1  sticky watchdog error
clr_err  in  1  clears err_timeout

Behaviour:
- Reset values: state IDLE; x_start 0; x_data 0; io_update 0; grant 00; err_timeout 0; rr pointer favours s0.
- Reset asserted mid-operation aborts any word or batch immediately. No io_update is issued afterwards.
- States: IDLE, ISSUE, WAIT, IOUP, GAP.
- Selection in IDLE:
  - If grant != 00, only the owner can be selected.
  - Otherwise, if both requesters are valid, the one the rr pointer favours is selected; if only one is valid, that one is selected.
  - sN_ready = (state==IDLE) && selected==N. Ready is combinational from state and the valid inputs. It is never high in other states.
- Handshake (valid & ready) in cycle T:
  - At T+1: x_data = sN_data; last_r = sN_last; grant = owner one-hot; state = ISSUE; x_start = 1.
  - At T+2: state = WAIT; x_start = 0; watchdog counter loads 0.
  - x_start is high for exactly one cycle per word.
- WAIT:
  - The counter increments each cycle.
  - x_done with last_r=0: go to GAP; grant is held.
  - x_done with last_r=1: go to IOUP.
  - Counter reaches TIMEOUT with no x_done: err_timeout=1, grant=00, go to GAP, no io_update.
  - x_done is ignored outside WAIT.
- IOUP: io_update is high for exactly IOUP_CYC cycles, then:
  - grant = 00;
  - rr pointer moves to favour the requester that did not own this batch;
  - state = GAP.
- GAP: GAP_CYC cycles, then IDLE. Earliest next handshake is the cycle IDLE is entered.
- Single-word batch (last=1 on first word): lock opens and closes within the same word.
- Simultaneous err set (timeout) and clr_err in the same cycle: set wins.
- x_data and grant do not change between x_start and the exit from WAIT.
- busy = (state != IDLE).

Test Plan:
- s0 sends a single word 0x0cd00d41 with last=1 after reset -> x_start one cycle after the handshake with x_data=0x0cd00d41; after x_done, io_update is high 2 cycles; grant returns to 00; s0_ready is next high 4 cycles after io_update falls.
- s1 sends a 3-word batch while s0 asserts valid from word 2 onward -> s0_ready stays 0 until s1's batch completes; exactly one io_update, after s1 word 3.
- s0 and s1 both valid in the first IDLE cycle after reset, each with last=1 -> s0 served first, then s1 (rr), then s0 again if both are still valid.
- Engine never pulses x_done -> err_timeout=1 at 255 cycles after WAIT entry; no io_update; grant=00; next word accepted after the gap; clr_err pulse -> err_timeout=0.
- rstn pulsed low while in WAIT of a non-last word -> all outputs return to reset values asynchronously; no io_update afterwards; a new batch from s1 is accepted.
- x_done pulsed during IDLE and during GAP -> ignored, no state change, no io_update.

Source files
------------

// File: rtl/dds_cmd_scheduler.sv
// Two-requester DDS word scheduler: batch-locked arbitration, one engine
// transfer per word, IO_update after each batch and an engine watchdog.
module dds_cmd_scheduler #(
  parameter int GAP_CYC  = 4,
  parameter int IOUP_CYC = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        s0_valid,
  input  logic [31:0] s0_data,
  input  logic        s0_last,
  output logic        s0_ready,
  input  logic        s1_valid,
  input  logic [31:0] s1_data,
  input  logic        s1_last,
  output logic        s1_ready,
  output logic        x_start,
  output logic [31:0] x_data,
  input  logic        x_done,
  output logic        io_update,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_timeout,
  input  logic        clr_err
);

  localparam int C1 = (GAP_CYC > IOUP_CYC) ? GAP_CYC : IOUP_CYC;
  localparam int CMAX = (C1 > TIMEOUT) ? C1 : TIMEOUT;
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    IOUP,
    GAP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last_r;
  logic          rr;
  logic          sel0;
  logic          sel1;

  // An open batch locks out the other requester.
  always_comb begin
    sel0 = 1'b0;
    sel1 = 1'b0;
    if (grant != 2'b00) begin
      sel0 = grant[0] & s0_valid;
      sel1 = grant[1] & s1_valid;
    end else if (s0_valid & s1_valid) begin
      sel0 = ~rr;
      sel1 = rr;
    end else begin
      sel0 = s0_valid;
      sel1 = s1_valid;
    end
  end

  assign s0_ready = (state == IDLE) & sel0;
  assign s1_ready = (state == IDLE) & sel1;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      cnt         <= '0;
      last_r      <= 1'b0;
      rr          <= 1'b0;
      x_start     <= 1'b0;
      x_data      <= '0;
      io_update   <= 1'b0;
      grant       <= 2'b00;
      err_timeout <= 1'b0;
    end else begin
      x_start <= 1'b0;
      if (clr_err)
        err_timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          if (sel0 | sel1) begin
            x_data  <= sel1 ? s1_data : s0_data;
            last_r  <= sel1 ? s1_last : s0_last;
            grant   <= {sel1, sel0};
            x_start <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (x_done) begin
            cnt       <= '0;
            io_update <= last_r;
            state     <= last_r ? IOUP : GAP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // set beats a same-cycle clr_err
            err_timeout <= 1'b1;
            grant       <= 2'b00;
            cnt         <= '0;
            state       <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IOUP: begin
          if (cnt == CW'(IOUP_CYC - 1)) begin
            io_update <= 1'b0;
            grant     <= 2'b00;
            rr        <= grant[0];
            cnt       <= '0;
            state     <= GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYC - 1))
            state <= IDLE;
          else
            cnt <= cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dds_cmd_scheduler.sv
// Bench for dds_cmd_scheduler: timeline-based reference model,
// directed scenarios with literal pins, then randomized traffic.
module tb_dds_cmd_scheduler;
  localparam int GAP  = 4;
  localparam int IOUP = 2;
  localparam int TMO  = 255;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        s0_valid, s0_last, s0_ready;
  logic        s1_valid, s1_last, s1_ready;
  logic [31:0] s0_data, s1_data, x_data;
  logic        x_start, x_done, io_update, busy, err_timeout, clr_err;
  logic [1:0]  grant;

  dds_cmd_scheduler #(
    .GAP_CYC(GAP), .IOUP_CYC(IOUP), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rstn(rstn),
    .s0_valid(s0_valid), .s0_data(s0_data),
    .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data),
    .s1_last(s1_last), .s1_ready(s1_ready),
    .x_start(x_start), .x_data(x_data), .x_done(x_done),
    .io_update(io_update), .grant(grant), .busy(busy),
    .err_timeout(err_timeout), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];

  // model: one record for the most recent word plus lock/rr/err
  bit          m_have;
  int          m_t, m_done, m_owner;
  bit          m_last;
  logic [31:0] m_xdata;
  logic [1:0]  m_grant;
  bit          m_rr, m_err;

  int eng_min, eng_max;
  bit eng_dead, rnd_gate, spur, rnd_clr, refill, force_clr;

  int hs_req[$];
  int hs_cyc[$];
  int start_cyc[$];
  logic [31:0] start_dat[$];
  int ioup_hi[$];
  int ioup_rise[$];
  int err_rise;
  int busy_seen;
  bit prev_ioup, prev_err;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  function automatic int end_wait();
    return (m_done >= 0) ? m_done + 1 : m_t + 2 + TMO;
  endfunction

  function automatic int idle_at();
    if (!m_have) return 0;
    return end_wait() + ((m_done >= 0 && m_last) ? IOUP : 0) + GAP;
  endfunction

  function automatic bit in_wait();
    return m_have && cyc >= m_t + 2 && cyc < end_wait();
  endfunction

  task automatic push_batch(int r);
    int n;
    n = $urandom_range(1, 3);
    for (int i = 0; i < n; i++) begin
      if (r == 0) q0.push_back({i == n - 1, $urandom()});
      else        q1.push_back({i == n - 1, $urandom()});
    end
  endtask

  task automatic clear_logs();
    hs_req.delete(); hs_cyc.delete();
    start_cyc.delete(); start_dat.delete();
    ioup_hi.delete(); ioup_rise.delete();
    err_rise = -1;
    busy_seen = 0;
  endtask

  task automatic cycle();
    logic [32:0] w0, w1;
    bit v0, v1, sel0, sel1, idle, hs0, hs1, set_err, io_exp;
    logic [1:0] ng;
    bit nrr;
    if (refill) begin
      if (q0.size() == 0 && $urandom_range(3) == 0) push_batch(0);
      if (q1.size() == 0 && $urandom_range(3) == 0) push_batch(1);
    end
    w0 = (q0.size() > 0) ? q0[0] : '0;
    w1 = (q1.size() > 0) ? q1[0] : '0;
    v0 = (q0.size() > 0) && (!rnd_gate || $urandom_range(3) != 0);
    v1 = (q1.size() > 0) && (!rnd_gate || $urandom_range(3) != 0);
    s0_valid = v0; s0_last = w0[32]; s0_data = w0[31:0];
    s1_valid = v1; s1_last = w1[32]; s1_data = w1[31:0];
    x_done = (m_have && m_done == cyc) ||
             (spur && !in_wait() && $urandom_range(4) == 0);
    clr_err = force_clr || (rnd_clr && $urandom_range(7) == 0);
    force_clr = 0;
    @(negedge clk);
    idle = !m_have || cyc >= idle_at();
    sel0 = 0;
    sel1 = 0;
    if (idle) begin
      if (m_grant != 2'b00) begin
        sel0 = m_grant[0] && v0;
        sel1 = m_grant[1] && v1;
      end else if (v0 && v1) begin
        sel0 = !m_rr;
        sel1 = m_rr;
      end else begin
        sel0 = v0;
        sel1 = v1;
      end
    end
    io_exp = m_have && m_done >= 0 && m_last &&
             cyc > m_done && cyc <= m_done + IOUP;
    chk("s0_ready", s0_ready, sel0);
    chk("s1_ready", s1_ready, sel1);
    chk("busy", busy, !idle);
    chk("x_start", x_start, m_have && cyc == m_t + 1);
    chk("x_data", x_data, m_xdata);
    chk("io_update", io_update, io_exp);
    chk("grant", grant, m_grant);
    chk("err_timeout", err_timeout, m_err);
    // observations for literal pins
    if (s0_valid && s0_ready) begin hs_req.push_back(0); hs_cyc.push_back(cyc); end
    if (s1_valid && s1_ready) begin hs_req.push_back(1); hs_cyc.push_back(cyc); end
    if (x_start) begin start_cyc.push_back(cyc); start_dat.push_back(x_data); end
    if (io_update) ioup_hi.push_back(cyc);
    if (io_update && !prev_ioup) ioup_rise.push_back(cyc);
    if (err_timeout && !prev_err) err_rise = cyc;
    if (busy) busy_seen++;
    prev_ioup = io_update;
    prev_err = err_timeout;
    // model advance
    hs0 = sel0;
    hs1 = sel1;
    set_err = m_have && m_done < 0 && (cyc + 1 == m_t + 2 + TMO);
    ng = m_grant;
    nrr = m_rr;
    if (set_err) ng = 2'b00;
    if (m_have && m_done >= 0 && m_last && cyc + 1 == m_done + 1 + IOUP) begin
      ng = 2'b00;
      nrr = (m_owner == 0);
    end
    m_err = set_err || (m_err && !clr_err);
    if (hs0 || hs1) begin
      m_have = 1;
      m_t = cyc;
      m_owner = hs1 ? 1 : 0;
      m_last = hs1 ? w1[32] : w0[32];
      m_xdata = hs1 ? w1[31:0] : w0[31:0];
      ng = hs1 ? 2'b10 : 2'b01;
      m_done = eng_dead ? -1 : cyc + 2 + $urandom_range(eng_min, eng_max);
      if (hs1) void'(q1.pop_front());
      else     void'(q0.pop_front());
    end
    m_grant = ng;
    m_rr = nrr;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wait_hs(int n);
    for (int i = 0; i < 60 && hs_cyc.size() < n; i++) cycle();
    chk("hs_wait", hs_cyc.size() >= n, 1);
  endtask

  task automatic do_reset();
    rstn = 0;
    s0_valid = 0; s1_valid = 0; s0_last = 0; s1_last = 0;
    s0_data = 0; s1_data = 0; x_done = 0; clr_err = 0;
    q0.delete(); q1.delete();
    m_have = 0; m_done = -1; m_grant = 0; m_rr = 0; m_err = 0; m_xdata = 0;
    eng_dead = 0; rnd_gate = 0; spur = 0; rnd_clr = 0; refill = 0;
    force_clr = 0;
    prev_ioup = 0; prev_err = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_rst_vals(string p);
    chk({p, "_x_start"}, x_start, 0);
    chk({p, "_x_data"}, x_data, 0);
    chk({p, "_io_update"}, io_update, 0);
    chk({p, "_grant"}, grant, 0);
    chk({p, "_busy"}, busy, 0);
    chk({p, "_err"}, err_timeout, 0);
  endtask

  initial begin
    int h;
    do_reset();
    chk_rst_vals("rst");
    chk("rst_s0_ready", s0_ready, 0);

    // single word, then a second to find the earliest re-accept
    clear_logs();
    eng_min = 3; eng_max = 3;
    q0.push_back({1'b1, 32'h0cd00d41});
    q0.push_back({1'b1, 32'h12345678});
    run(35);
    chk("t1_hs_n", hs_req.size(), 2);
    chk("t1_ioup_n", ioup_hi.size(), 4);
    if (hs_cyc.size() >= 2 && start_cyc.size() >= 1 && ioup_hi.size() >= 2) begin
      h = hs_cyc[0];
      chk("t1_start_lat", start_cyc[0], h + 1);
      chk("t1_start_dat", start_dat[0], 32'h0cd00d41);
      chk("t1_ioup0", ioup_hi[0], h + 6);
      chk("t1_ioup1", ioup_hi[1], h + 7);
      chk("t1_reaccept", hs_cyc[1], ioup_hi[1] + 1 + GAP);
    end

    // s1 batch locks out s0
    do_reset();
    clear_logs();
    eng_min = 2; eng_max = 5;
    q1.push_back({1'b0, 32'ha1a1a1a1});
    q1.push_back({1'b0, 32'ha2a2a2a2});
    q1.push_back({1'b1, 32'ha3a3a3a3});
    wait_hs(1);
    q0.push_back({1'b1, 32'hb0b0b0b0});
    run(100);
    chk("t2_hs_n", hs_req.size(), 4);
    chk("t2_rise_n", ioup_rise.size(), 2);
    if (hs_req.size() == 4 && ioup_rise.size() >= 1) begin
      chk("t2_ord", {hs_req[0][3:0], hs_req[1][3:0], hs_req[2][3:0], hs_req[3][3:0]},
          32'h1110);
      chk("t2_ioup_after3", ioup_rise[0] > hs_cyc[2], 1);
      chk("t2_ioup_before_s0", ioup_rise[0] < hs_cyc[3], 1);
    end

    // round robin with both valid from the first idle cycle
    do_reset();
    clear_logs();
    eng_min = 1; eng_max = 3;
    q0.push_back({1'b1, 32'h00000001});
    q0.push_back({1'b1, 32'h00000002});
    q1.push_back({1'b1, 32'h10000001});
    q1.push_back({1'b1, 32'h10000002});
    run(90);
    chk("t3_hs_n", hs_req.size(), 4);
    if (hs_req.size() == 4)
      chk("t3_ord", {hs_req[0][3:0], hs_req[1][3:0], hs_req[2][3:0], hs_req[3][3:0]},
          32'h0101);

    // watchdog
    do_reset();
    clear_logs();
    eng_min = 2; eng_max = 2;
    eng_dead = 1;
    q0.push_back({1'b0, 32'hdeadbeef});
    wait_hs(1);
    eng_dead = 0;
    q1.push_back({1'b1, 32'hcafef00d});
    run(300);
    chk("t4_hs_n", hs_req.size(), 2);
    chk("t4_rise_n", ioup_rise.size(), 1);
    if (hs_req.size() == 2 && ioup_rise.size() == 1) begin
      chk("t4_err_at", err_rise, hs_cyc[0] + 2 + 255);
      chk("t4_next", hs_cyc[1], hs_cyc[0] + 2 + 255 + GAP);
      chk("t4_next_req", hs_req[1], 1);
      chk("t4_no_ioup", ioup_rise[0] > hs_cyc[1], 1);
    end
    chk("t4_err_held", err_timeout, 1);
    force_clr = 1;
    cycle();
    chk("t4_clr", err_timeout, 0);

    // async reset in WAIT of a non-last word
    do_reset();
    clear_logs();
    eng_min = 20; eng_max = 20;
    q0.push_back({1'b0, 32'h5555aaaa});
    q0.push_back({1'b1, 32'h6666bbbb});
    wait_hs(1);
    run(4);
    chk("t5_busy_pre", busy, 1);
    #1;
    rstn = 0;
    #1;
    chk_rst_vals("t5_async");
    do_reset();
    clear_logs();
    eng_min = 2; eng_max = 2;
    q1.push_back({1'b1, 32'h77778888});
    run(40);
    chk("t5_hs_n", hs_req.size(), 1);
    chk("t5_rise_n", ioup_rise.size(), 1);
    if (hs_req.size() == 1 && ioup_rise.size() == 1) begin
      chk("t5_req", hs_req[0], 1);
      chk("t5_ioup_late", ioup_rise[0] > hs_cyc[0], 1);
    end

    // stray x_done in IDLE
    do_reset();
    clear_logs();
    spur = 1;
    run(20);
    chk("t6_busy_seen", busy_seen, 0);
    chk("t6_rise_n", ioup_rise.size(), 0);

    // randomized traffic with stray x_done during GAP/IDLE
    clear_logs();
    eng_min = 0; eng_max = 6;
    rnd_gate = 1; spur = 1; rnd_clr = 1; refill = 1;
    run(3000);
    chk("rnd_activity", hs_req.size() > 50, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
